fft_peak_analyzer: RTL and testbench

Downstream analysis stage for the FAS FFT output bus. It captures one 16-point FFT frame when `fft_valid` pulses, and computes the squared magnitude of each bin, one bin per cycle. It then reports the index of the strongest bin on `freq` with a one-cycle `done` pulse. This block is the consumer of the `fft_valid`/`fft_d0..fft_d15` bus that the FAS FFT stage produces. It replaces bench-side inspection with the in-design `done`/`freq` result.

---
 rtl/fft_peak_analyzer.sv | 153 +++++++++++++++
 tb/tb_fft_peak_analyzer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_analyzer.sv
// fft_peak_analyzer
// Captures one 16-bin FFT frame on i_fft_valid, scans the bins one per cycle
// computing re*re + im*im, and reports the index of the strongest bin
// (lowest index wins ties) on o_freq together with a one-cycle o_done pulse.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_fft_valid    single-cycle frame strobe
//   i_fft_d0..15   bin k = {real[2*DW-1:DW], imag[DW-1:0]}, two's complement
//   o_done         one-cycle pulse, o_freq has just been updated
//   o_freq         index of the peak bin of the last completed frame
//   o_busy         high while a frame is being scanned
//   o_overrun      sticky, a frame arrived mid-scan and was dropped
//
// state  | meaning
// IDLE   | waiting for a frame
// SCAN   | evaluating bin r_idx, one bin per cycle
// REPORT | o_done is high for this cycle
module fft_peak_analyzer #(
   parameter int DW = 16
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_fft_valid,
   input  logic [2*DW-1:0] i_fft_d0,
   input  logic [2*DW-1:0] i_fft_d1,
   input  logic [2*DW-1:0] i_fft_d2,
   input  logic [2*DW-1:0] i_fft_d3,
   input  logic [2*DW-1:0] i_fft_d4,
   input  logic [2*DW-1:0] i_fft_d5,
   input  logic [2*DW-1:0] i_fft_d6,
   input  logic [2*DW-1:0] i_fft_d7,
   input  logic [2*DW-1:0] i_fft_d8,
   input  logic [2*DW-1:0] i_fft_d9,
   input  logic [2*DW-1:0] i_fft_d10,
   input  logic [2*DW-1:0] i_fft_d11,
   input  logic [2*DW-1:0] i_fft_d12,
   input  logic [2*DW-1:0] i_fft_d13,
   input  logic [2*DW-1:0] i_fft_d14,
   input  logic [2*DW-1:0] i_fft_d15,
   output logic            o_done,
   output logic [3:0]      o_freq,
   output logic            o_busy,
   output logic            o_overrun
);

   typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

   state_t                 r_state, w_state_nxt;
   logic [2*DW-1:0]        r_bank [16];
   logic [2*DW-1:0]        w_frame [16];
   logic [3:0]             r_idx;
   logic [2*DW-1:0]        r_max_mag;
   logic [3:0]             r_max_idx;
   logic                   r_done;
   logic [3:0]             r_freq;
   logic                   r_overrun;

   logic                   w_accept;
   logic                   w_last;
   logic signed [DW-1:0]   w_re, w_im;
   logic signed [2*DW-1:0] w_re_sq, w_im_sq;
   logic [2*DW-1:0]        w_mag;
   logic                   w_gt;
   logic [3:0]             w_best_idx;

   assign w_frame[0]  = i_fft_d0;
   assign w_frame[1]  = i_fft_d1;
   assign w_frame[2]  = i_fft_d2;
   assign w_frame[3]  = i_fft_d3;
   assign w_frame[4]  = i_fft_d4;
   assign w_frame[5]  = i_fft_d5;
   assign w_frame[6]  = i_fft_d6;
   assign w_frame[7]  = i_fft_d7;
   assign w_frame[8]  = i_fft_d8;
   assign w_frame[9]  = i_fft_d9;
   assign w_frame[10] = i_fft_d10;
   assign w_frame[11] = i_fft_d11;
   assign w_frame[12] = i_fft_d12;
   assign w_frame[13] = i_fft_d13;
   assign w_frame[14] = i_fft_d14;
   assign w_frame[15] = i_fft_d15;

   // Bin is read from the bank before any same-edge recapture lands, so a
   // new frame accepted on the idx==15 cycle does not corrupt bin 15.
   assign w_re    = r_bank[r_idx][2*DW-1:DW];
   assign w_im    = r_bank[r_idx][DW-1:0];
   assign w_re_sq = w_re * w_re;
   assign w_im_sq = w_im * w_im;
   // Each square is <= 2^(2DW-2), so the unsigned sum tops out at 2^(2DW-1).
   assign w_mag   = $unsigned(w_re_sq) + $unsigned(w_im_sq);

   assign w_gt       = w_mag > r_max_mag;
   assign w_best_idx = w_gt ? r_idx : r_max_idx;

   assign w_last   = (r_state == SCAN) && (r_idx == 4'd15);
   assign w_accept = i_fft_valid && ((r_state != SCAN) || (r_idx == 4'd15));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = SCAN;
         SCAN:    if (r_idx == 4'd15) w_state_nxt = w_accept ? SCAN : REPORT;
         REPORT:  w_state_nxt = w_accept ? SCAN : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 16; i++) r_bank[i] <= '0;
         r_idx     <= '0;
         r_max_mag <= '0;
         r_max_idx <= '0;
         r_done    <= 1'b0;
         r_freq    <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_accept) begin
            for (int i = 0; i < 16; i++) r_bank[i] <= w_frame[i];
            r_idx     <= '0;
            r_max_mag <= '0;
            r_max_idx <= '0;
         end else if (r_state == SCAN) begin
            r_idx <= r_idx + 4'd1;
            if (w_gt) begin
               r_max_mag <= w_mag;
               r_max_idx <= r_idx;
            end
         end

         r_done <= w_last;
         if (w_last) r_freq <= w_best_idx;

         if (i_fft_valid && !w_accept) r_overrun <= 1'b1;
      end
   end

   assign o_done    = r_done;
   assign o_freq    = r_freq;
   assign o_busy    = (r_state == SCAN);
   assign o_overrun = r_overrun;

endmodule

// File: tb/tb_fft_peak_analyzer.sv
module tb_fft_peak_analyzer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fft_valid = 1'b0;
   logic [31:0] frame [16];
   logic        done;
   logic [3:0]  freq;
   logic        busy;
   logic        overrun;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   fft_peak_analyzer #(.DW(16)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_fft_valid(fft_valid),
      .i_fft_d0(frame[0]),   .i_fft_d1(frame[1]),   .i_fft_d2(frame[2]),   .i_fft_d3(frame[3]),
      .i_fft_d4(frame[4]),   .i_fft_d5(frame[5]),   .i_fft_d6(frame[6]),   .i_fft_d7(frame[7]),
      .i_fft_d8(frame[8]),   .i_fft_d9(frame[9]),   .i_fft_d10(frame[10]), .i_fft_d11(frame[11]),
      .i_fft_d12(frame[12]), .i_fft_d13(frame[13]), .i_fft_d14(frame[14]), .i_fft_d15(frame[15]),
      .o_done(done), .o_freq(freq), .o_busy(busy), .o_overrun(overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: argmax of re^2+im^2 over the frame, first occurrence wins.
   function automatic int ref_peak();
      longint best = -1;
      int     bi   = 0;
      for (int k = 0; k < 16; k++) begin
         logic [31:0] w;
         longint re, im, m;
         w  = frame[k];
         re = longint'($signed(w[31:16]));
         im = longint'($signed(w[15:0]));
         m  = re * re + im * im;
         if (m > best) begin
            best = m;
            bi   = k;
         end
      end
      return bi;
   endfunction

   task automatic fill(input logic [31:0] v);
      for (int k = 0; k < 16; k++) frame[k] = v;
   endtask

   task automatic peak_frame(input int p);
      fill(32'h0010_0010);
      frame[p] = 32'h0400_0000;
   endtask

   // Drive the strobe for one edge, then sit 1 time unit after it.
   task automatic step(input bit v);
      fft_valid = v;
      @(posedge clk);
      #1;
      fft_valid = 1'b0;
   endtask

   // Launch the current frame and check done/freq/busy over the next 16 edges.
   task automatic run_single(input string tag);
      int exp_f;
      int busy_cnt;
      exp_f = ref_peak();
      step(1'b1);
      busy_cnt = busy ? 1 : 0;
      chk({tag, "_done_n"}, {31'd0, done}, 32'd0);
      for (int k = 1; k <= 16; k++) begin
         step(1'b0);
         if (busy) busy_cnt++;
         chk({tag, "_done"}, {31'd0, done}, (k == 16) ? 32'd1 : 32'd0);
         if (k == 16) chk({tag, "_freq"}, {28'd0, freq}, exp_f);
      end
      chk({tag, "_busy_cycles"}, busy_cnt, 32'd16);
      step(1'b0);
      chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int p_seq [4];
      int prev_f;
      fill(32'h0);

      // Reset state
      #2;
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_freq", {28'd0, freq}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ovr",  {31'd0, overrun}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step(1'b0);

      // Single peak
      peak_frame(1);
      run_single("single");
      chk("single_ovr", {31'd0, overrun}, 32'd0);

      // Tie: lowest index wins
      fill(32'h0);
      frame[3]  = 32'h0200_FE00;
      frame[12] = 32'h0200_FE00;
      run_single("tie");

      // Sign: 0x8000 squared beats 0x7FFF squared
      fill(32'h0);
      frame[2]  = 32'h7FFF_0000;
      frame[15] = 32'h8000_0000;
      run_single("sign");

      // Extreme magnitude
      fill(32'h0);
      frame[9] = 32'h8000_8000;
      frame[4] = 32'h7FFF_7FFF;
      run_single("extreme");

      // Randomized frames against the model
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 16; k++) frame[k] = $urandom;
         if (r == 1) frame[13] = frame[6];
         run_single("rand");
      end

      // Back-to-back frames, done for frame f-1 coincides with capture of f
      p_seq[0] = 1; p_seq[1] = 15; p_seq[2] = 1; p_seq[3] = 15;
      prev_f = 0;
      for (int f = 0; f < 4; f++) begin
         peak_frame(p_seq[f]);
         step(1'b1);
         chk("b2b_busy0", {31'd0, busy}, 32'd1);
         chk("b2b_done_at_cap", {31'd0, done}, (f > 0) ? 32'd1 : 32'd0);
         if (f > 0) chk("b2b_freq", {28'd0, freq}, prev_f);
         prev_f = ref_peak();
         for (int k = 1; k < 16; k++) begin
            step(1'b0);
            chk("b2b_busy", {31'd0, busy}, 32'd1);
            chk("b2b_done_n", {31'd0, done}, 32'd0);
         end
      end
      step(1'b0);
      chk("b2b_last_done", {31'd0, done}, 32'd1);
      chk("b2b_last_freq", {28'd0, freq}, prev_f);
      chk("b2b_ovr", {31'd0, overrun}, 32'd0);
      repeat (2) step(1'b0);

      // Overrun
      peak_frame(5);
      prev_f = ref_peak();
      step(1'b1);
      for (int k = 1; k <= 5; k++) step(1'b0);
      chk("ovr_pre", {31'd0, overrun}, 32'd0);
      peak_frame(7);
      step(1'b1);
      chk("ovr_set", {31'd0, overrun}, 32'd1);
      for (int k = 7; k <= 16; k++) begin
         step(1'b0);
         chk("ovr_done", {31'd0, done}, (k == 16) ? 32'd1 : 32'd0);
         if (k == 16) chk("ovr_freq", {28'd0, freq}, prev_f);
      end
      for (int k = 0; k < 20; k++) begin
         step(1'b0);
         chk("ovr_no_2nd_done", {31'd0, done}, 32'd0);
      end
      chk("ovr_sticky", {31'd0, overrun}, 32'd1);

      // Reset mid-scan
      peak_frame(11);
      step(1'b1);
      for (int k = 1; k <= 8; k++) step(1'b0);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_freq", {28'd0, freq}, 32'd0);
      chk("mid_rst_ovr",  {31'd0, overrun}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step(1'b0);
         chk("mid_no_done", {31'd0, done}, 32'd0);
      end

      // All-zero frame
      fill(32'h0);
      run_single("zero");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
